// File: rtl/mc_cmd_decode_queue_if.sv
// Command/queue handshake bundle for mc_cmd_decode_queue.
// master: host + scheduler side (drives commands, consumes queue head).
// slave : decoder/queue side.
interface mc_cmd_decode_queue_if #(
    parameter int unsigned CMD_W  = 32,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned DEPTH  = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [CMD_W-1:0]         cmd_input;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_cmd;
    logic [BANK_W-1:0]        out_bank;
    logic [ROW_W-1:0]         out_row;
    logic [COL_W-1:0]         out_col;
    logic                     out_err;
    logic [$clog2(DEPTH):0]   out_count;

    modport master (
        output cmd_valid, cmd_input, out_ready,
        input  cmd_ready, out_valid, out_cmd, out_bank, out_row, out_col, out_err, out_count
    );

    modport slave (
        input  cmd_valid, cmd_input, out_ready,
        output cmd_ready, out_valid, out_cmd, out_bank, out_row, out_col, out_err, out_count
    );
endinterface

// File: rtl/mc_cmd_decode_queue.sv
// MC command decoder with per-bank open-row tracking and a DEPTH-entry output FIFO.
// Raw commands are decoded, checked against bank state and enqueued in the accept cycle;
// the head is visible one cycle later. Optional REFRESH decode enabled by the macro
// MC_CMD_REFRESH_EN (opcode 0101, legal only when every bank is closed).
module mc_cmd_decode_queue #(
    parameter int unsigned CMD_W  = 32,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned DEPTH  = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    mc_cmd_decode_queue_if.slave bus
);
    localparam int unsigned NBANK = 1 << BANK_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpAct = 4'h1;
    localparam logic [3:0] OpRd  = 4'h2;
    localparam logic [3:0] OpWr  = 4'h3;
    localparam logic [3:0] OpPre = 4'h4;
`ifdef MC_CMD_REFRESH_EN
    localparam logic [3:0] OpRef = 4'h5;
`endif

    // Field slices of the raw command
    logic [3:0]        opcode;
    logic [BANK_W-1:0] f_bank;
    logic [ROW_W-1:0]  f_row;
    logic [COL_W-1:0]  f_col;
    logic              unused_cmd_bits;

    assign opcode          = bus.cmd_input[CMD_W-1 -: 4];
    assign f_col           = bus.cmd_input[COL_W-1:0];
    assign f_row           = bus.cmd_input[COL_W +: ROW_W];
    assign f_bank          = bus.cmd_input[COL_W+ROW_W +: BANK_W];
    // Filler bits between opcode and bank carry no meaning
    assign unused_cmd_bits = ^bus.cmd_input;

    // Bank state
    logic [NBANK-1:0] open_q, open_d;
    logic [ROW_W-1:0] row_q [NBANK];
    logic [ROW_W-1:0] row_d [NBANK];

    // Queue storage and control
    logic [3:0]        q_cmd  [DEPTH];
    logic [BANK_W-1:0] q_bank [DEPTH];
    logic [ROW_W-1:0]  q_row  [DEPTH];
    logic [COL_W-1:0]  q_col  [DEPTH];
    logic              q_err  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;

    logic       push, pop, head_valid;
    logic [3:0] dec_cmd;
    logic       dec_err;

    assign head_valid = (count_q != '0);
    assign push       = bus.cmd_valid & ready_q;
    assign pop        = head_valid & bus.out_ready;

    // Decode opcode, check bank legality, compute bank-state update for an accepted command
    always_comb begin
        dec_cmd = OpNop;
        dec_err = 1'b0;
        open_d  = open_q;
        row_d   = row_q;
        case (opcode)
            OpNop: ;
            OpAct: begin
                dec_cmd = OpAct;
                if (open_q[f_bank]) begin
                    dec_err = 1'b1;
                end else if (push) begin
                    open_d[f_bank] = 1'b1;
                    row_d[f_bank]  = f_row;
                end
            end
            OpRd, OpWr: begin
                dec_cmd = opcode;
                dec_err = !(open_q[f_bank] && (row_q[f_bank] == f_row));
            end
            OpPre: begin
                dec_cmd = OpPre;
                if (push) open_d[f_bank] = 1'b0;
            end
`ifdef MC_CMD_REFRESH_EN
            OpRef: begin
                dec_cmd = OpRef;
                dec_err = |open_q;
            end
`endif
            default: begin
                dec_cmd = OpNop;
                dec_err = 1'b1;
            end
        endcase
    end

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; ready is registered from next occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            open_q   <= '0;
            for (int i = 0; i < NBANK; i++) row_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d < DepthC);
            open_q   <= open_d;
            row_q    <= row_d;
        end
    end

    // Queue storage write on accept
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            q_cmd[wr_ptr_q]  <= dec_cmd;
            q_bank[wr_ptr_q] <= f_bank;
            q_row[wr_ptr_q]  <= f_row;
            q_col[wr_ptr_q]  <= f_col;
            q_err[wr_ptr_q]  <= dec_err;
        end
    end

    // Head outputs, forced to zero when the queue is empty
    always_comb begin
        bus.cmd_ready = ready_q;
        bus.out_valid = head_valid;
        bus.out_count = count_q;
        bus.out_cmd   = '0;
        bus.out_bank  = '0;
        bus.out_row   = '0;
        bus.out_col   = '0;
        bus.out_err   = 1'b0;
        if (head_valid) begin
            bus.out_cmd  = q_cmd[rd_ptr_q];
            bus.out_bank = q_bank[rd_ptr_q];
            bus.out_row  = q_row[rd_ptr_q];
            bus.out_col  = q_col[rd_ptr_q];
            bus.out_err  = q_err[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_mc_cmd_decode_queue.sv
// Self-checking bench for mc_cmd_decode_queue: decode/bank-check vector table plus
// hand-written fill, wrap and reset sequences against a queue scoreboard.
module tb_mc_cmd_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [2:0]  bank;
        logic [13:0] row;
        logic [9:0]  col;
        logic        err;
    } ent_t;

    typedef struct {
        logic [3:0] op;
        ent_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    mc_cmd_decode_queue_if #(
        .CMD_W(32), .BANK_W(3), .ROW_W(14), .COL_W(10), .DEPTH(DEPTH)
    ) bus ();

    mc_cmd_decode_queue #(
        .CMD_W(32), .BANK_W(3), .ROW_W(14), .COL_W(10), .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic ent_t mk(input logic [3:0] c, input int b, input int r, input int cl,
                                input logic e);
        mk = {c, 3'(b), 14'(r), 10'(cl), e};
    endfunction

    function automatic vec_t mv(input logic [3:0] op, input ent_t e);
        mv.op  = op;
        mv.exp = e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ent_t head();
        head = {bus.out_cmd, bus.out_bank, bus.out_row, bus.out_col, bus.out_err};
    endfunction

    // Called at negedge: check DUT against scoreboard, drive one cycle, update scoreboard
    task automatic step(input logic v, input logic [3:0] op, input ent_t e, input logic r,
                        output logic acc);
        logic pop;
        check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_q.size() < DEPTH));
        check("out_count", 32'(bus.out_count), exp_q.size());
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("head", head(), exp_q[0]);
        bus.cmd_valid = v;
        bus.cmd_input = {op, 1'b0, e.bank, e.row, e.col};
        bus.out_ready = r;
        acc = v && (exp_q.size() < DEPTH);
        pop = r && (exp_q.size() != 0);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
        @(negedge clk);
    endtask

    vec_t vec[16];
    logic acc;
    int   idx;

    initial begin
        // Decode / bank-state table, one command per cycle with the scheduler always ready
        vec[0]  = mv(4'h1, mk(4'h1, 2, 'h55, 0, 1'b0));       // ACT b2
        vec[1]  = mv(4'h2, mk(4'h2, 2, 'h55, 'h10, 1'b0));    // RD b2 same row
        vec[2]  = mv(4'h2, mk(4'h2, 1, 0, 0, 1'b1));          // RD closed b1
        vec[3]  = mv(4'h1, mk(4'h1, 3, 100, 0, 1'b0));        // ACT b3
        vec[4]  = mv(4'h1, mk(4'h1, 3, 200, 0, 1'b1));        // ACT open b3
        vec[5]  = mv(4'h2, mk(4'h2, 3, 200, 5, 1'b1));        // RD b3 wrong row
        vec[6]  = mv(4'h3, mk(4'h3, 3, 100, 7, 1'b0));        // WR b3 correct row
        vec[7]  = mv(4'hA, mk(4'h0, 4, 7, 3, 1'b1));          // invalid opcode
        vec[8]  = mv(4'h0, mk(4'h0, 0, 9, 1, 1'b0));          // NOP
        vec[9]  = mv(4'h4, mk(4'h4, 3, 0, 0, 1'b0));          // PRE b3
        vec[10] = mv(4'h4, mk(4'h4, 5, 0, 0, 1'b0));          // PRE closed b5
        vec[11] = mv(4'h4, mk(4'h4, 2, 0, 0, 1'b0));          // PRE b2, all closed now
`ifdef MC_CMD_REFRESH_EN
        vec[12] = mv(4'h5, mk(4'h5, 0, 0, 0, 1'b0));          // REFRESH, banks closed
`else
        vec[12] = mv(4'h5, mk(4'h0, 0, 0, 0, 1'b1));
`endif
        vec[13] = mv(4'h2, mk(4'h2, 2, 'h55, 0, 1'b1));       // RD after PRE
        vec[14] = mv(4'h1, mk(4'h1, 7, 'h3FFF, 'h3FF, 1'b0)); // ACT max fields
`ifdef MC_CMD_REFRESH_EN
        vec[15] = mv(4'h5, mk(4'h5, 0, 0, 0, 1'b1));          // REFRESH with b7 open
`else
        vec[15] = mv(4'h5, mk(4'h0, 0, 0, 0, 1'b1));
`endif

        bus.cmd_valid = 1'b0;
        bus.cmd_input = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_count", 32'(bus.out_count), 0);
        check("rst_head", head(), 0);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 16; i++) step(1'b1, vec[i].op, vec[i].exp, 1'b1, acc);
        step(1'b0, 4'h0, '0, 1'b1, acc);
        step(1'b0, 4'h0, '0, 1'b0, acc);

        // Fill: hold scheduler off, offer DEPTH+2 NOPs, host holds each until accepted
        idx = 0;
        repeat (DEPTH + 2) begin
            step(1'b1, 4'h0, mk(4'h0, idx, idx * 3, idx, 1'b0), 1'b0, acc);
            if (acc) idx++;
        end
        check("fill_accepted", idx, DEPTH);

        // Full queue with simultaneous push/pop for 10 cycles wraps the pointers
        repeat (10) begin
            step(1'b1, 4'h0, mk(4'h0, idx, idx * 3, idx, 1'b0), 1'b1, acc);
            if (acc) idx++;
        end

        // Drain
        repeat (DEPTH + 1) step(1'b0, 4'h0, '0, 1'b1, acc);

        // Reset with entries queued (bank 0 opened by the first one)
        step(1'b1, 4'h1, mk(4'h1, 0, 0, 0, 1'b0), 1'b0, acc);
        step(1'b1, 4'h0, mk(4'h0, 1, 1, 1, 1'b0), 1'b0, acc);
        step(1'b1, 4'h0, mk(4'h0, 2, 2, 2, 1'b0), 1'b0, acc);
        check("pre_rst_count", 32'(bus.out_count), 3);
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_out_count", 32'(bus.out_count), 0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 0);
        exp_q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 4'h2, mk(4'h2, 0, 0, 0, 1'b1), 1'b1, acc); // RD b0: closed after reset
        step(1'b0, 4'h0, '0, 1'b1, acc);
        step(1'b0, 4'h0, '0, 1'b0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
